// File: rtl/timer_pkg.sv
// Shared definitions for the loadable countdown timer.
// Holds the state encoding and the default counter width.
package timer_pkg;

    localparam int TMR_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } tmr_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a valid/ready load port, one-cycle
// terminal-count pulse and optional automatic reload.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TMR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             tick_en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    tmr_state_t       state;
    tmr_state_t       state_nxt;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_nxt;
    logic             tc_q;
    logic             tc_nxt;
    logic             load_acc;
    logic             go;
    logic             term;

    assign load_acc = load_valid && (state != RUN);
    assign go       = start && !stop;
    assign term     = (cnt_q == WIDTH'(1));

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt_q;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_acc) begin
                    cnt_nxt    = load_value;
                    reload_nxt = load_value;
                    state_nxt  = ARMED;
                end
            end
            ARMED: begin
                if (load_acc) begin
                    cnt_nxt    = load_value;
                    reload_nxt = load_value;
                end else if (go) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // stop beats a terminal tick: no pulse, no decrement
                if (stop) begin
                    state_nxt = ARMED;
                end else if (tick_en && term) begin
                    tc_nxt = 1'b1;
                    if (auto_reload) begin
                        cnt_nxt = reload_q;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end
                end else if (tick_en) begin
                    cnt_nxt = cnt_q - WIDTH'(1);
                end
            end
            DONE: begin
                if (load_acc) begin
                    cnt_nxt    = load_value;
                    reload_nxt = load_value;
                    state_nxt  = ARMED;
                end else if (go) begin
                    cnt_nxt   = reload_q;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            state    <= state_nxt;
            cnt_q    <= cnt_nxt;
            reload_q <= reload_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_nxt;
        end
    end

    assign cnt        = cnt_q;
    assign tc         = tc_q;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign load_ready = (state != RUN);

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter/timer, the decrementing counterpart of the team's 4-bit free-running up-counter. Software or a controller loads a period through a valid/ready handshake, then starts it. The block counts down on qualified ticks, emits a one-cycle terminal-count pulse, and either reloads automatically or stops in a DONE state. It provides delays and periodic events for the CPU datapath control.

## Interface
- WIDTH, default 4: counter and load-value width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load request.
- load_ready  out  1  block can accept a load.
- load_value  in  WIDTH  period in ticks; 0 means 2^WIDTH.
- start  in  1  begin or resume counting.
- stop  in  1  pause counting.
- auto_reload  in  1  sampled at terminal count; 1 means reload and keep running.
- tick_en  in  1  decrement qualifier (prescaler strobe).
- cnt  out  WIDTH  current count.
- tc  out  1  terminal-count pulse.
- busy  out  1  state is RUN.
- done  out  1  state is DONE.

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset enters IDLE.
- Registers: cnt, reload_reg (WIDTH), tc, state.
- Load handshake:
  - load_ready=1 in IDLE, ARMED and DONE; 0 in RUN.
  - A load is accepted when load_valid&&load_ready.
  - On acceptance: cnt<=load_value, reload_reg<=load_value, state<=ARMED.
  - load_valid in RUN is ignored and does not stall; the requester must hold it until ready.
- IDLE: start and stop are ignored; only a load leaves IDLE.
- ARMED:
  - start&&!stop moves to RUN.
  - cnt holds.
  - A load in the same cycle as start takes priority: the load is applied and the state stays ARMED.
- RUN, on each cycle with tick_en=1:
  - cnt!=1: cnt<=cnt-1, modulo 2^WIDTH, so 0 wraps to all-ones.
  - cnt==1 and auto_reload=1: cnt<=reload_reg, tc<=1, stay in RUN.
  - cnt==1 and auto_reload=0: cnt<=0, tc<=1, state<=DONE.
- RUN, other cases:
  - tick_en=0: cnt holds.
  - stop=1: state<=ARMED and cnt holds, regardless of tick_en. Stop wins over a simultaneous terminal tick: no tc and no decrement.
  - start is ignored.
- DONE:
  - done=1, cnt=0.
  - start&&!stop: cnt<=reload_reg, state<=RUN.
  - An accepted load moves to ARMED and has priority over start.
- Period: exactly reload ticks, or 2^WIDTH ticks for a load of 0, between tc pulses in auto-reload mode.
- Reset mid-operation: all state is cleared asynchronously and reload_reg<=0.

## Timing
- Reset values: cnt=0, tc=0, busy=0, done=0, load_ready=1.
- All outputs are registered or decoded from registered state only. There is no combinational input-to-output path.
- Load: cnt reflects load_value in the cycle after acceptance.
- Start:
  - The state is RUN in the cycle after start is sampled.
  - tick_en in the start cycle is not counted.
  - The first decrement is visible in the cycle after the first tick_en seen while in RUN.
- tc:
  - High for exactly one cycle, coincident with cnt showing its post-terminal value (reload_reg or 0).
  - Never high for two consecutive cycles unless reload_reg==1 and tick_en is held high, in which case it is continuous.
- busy and done change in the same cycle as the state.

## Structure
- Shared package timer_pkg holds:
  - state enum tmr_state_t (IDLE, ARMED, RUN, DONE), 2-bit encoding;
  - localparam TMR_DEFAULT_WIDTH=4.
- Single module, no sub-modules. The next-state/next-count logic is one combinational block with one sequential block; the tc register is separate.

## Test plan
- Reset then load 5, start, tick_en=1 continuously: cnt goes 5,4,3,2,1,0; tc is high on the cycle cnt=0; done=1 after; busy falls at the same time.
- auto_reload=1, load 3, tick_en every other cycle: tc pulses every 6 clocks; cnt cycles 3,2,1,3,...
- Load 0, tick_en=1: cnt goes 0,15,14,...,1,0; tc after exactly 16 ticks.
- Stop asserted at cnt=2 together with tick_en: cnt stays 2, state ARMED, no tc; start resumes and tc occurs 2 ticks later. Also start and stop together in ARMED: no transition.
- Load attempted during RUN: load_ready=0 and cnt is unaffected. In DONE, start alone restarts from reload_reg; start plus load applies the load and enters ARMED.
- rst_n pulsed low asynchronously mid-RUN at cnt=7, between clock edges: cnt=0 and load_ready=1 immediately; a later start is ignored until a load.
